// File: rtl/vec_dot_arbiter_if.sv
// ---------------------------------------------------------------------------
// vec_dot_arbiter_if
//   Request/response bus between the PE-array row controllers and the
//   shared dot-product arbiter.
//
//   req_valid  [NREQ]        per-requester request
//   req_ready  [NREQ]        one-hot grant; operands captured this cycle
//   req_a/req_b [NREQ*VEC_W] operands, requester k at [k*VEC_W +: VEC_W]
//   rsp_valid / rsp_ready    result handshake
//   rsp_id    [ID_W]         owner of the result
//   rsp_data  [OUT_W]        Q4.11 dot result (0 on error)
//   rsp_err                  engine timed out
//
//   master: requester side, slave: arbiter side.
// ---------------------------------------------------------------------------
interface vec_dot_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int VEC_W = 256,
   parameter int OUT_W = 16
);
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*VEC_W-1:0] req_a;
   logic [NREQ*VEC_W-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [OUT_W-1:0]      rsp_data;
   logic                  rsp_err;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/vec_dot_arbiter.sv
// ---------------------------------------------------------------------------
// vec_dot_arbiter
//   Round-robin arbiter/sequencer sharing one 16-lane Q4.11 dot-product
//   engine among NREQ requesters. One operation is outstanding at a time:
//   grant + operand capture (IDLE), one clear cycle (LOAD), engine run with
//   timeout (RUN), then the tagged result is held until consumed (RESP).
//
//   clk, rst    clock, synchronous active-high reset
//   bus         request/response bus (slave modport)
//   eng_clr     engine synchronous clear; high in reset, IDLE and LOAD
//   eng_a/eng_b latched operands driven to the engine
//   eng_finish  engine done (level), only looked at in RUN
//   eng_dot     engine result, valid while eng_finish is high
//   busy        operation in progress (state != IDLE)
// ---------------------------------------------------------------------------
module vec_dot_arbiter #(
   parameter int NREQ    = 4,
   parameter int VEC_W   = 256,
   parameter int OUT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   vec_dot_arbiter_if.slave  bus,
   output logic              eng_clr,
   output logic [VEC_W-1:0]  eng_a,
   output logic [VEC_W-1:0]  eng_b,
   input  logic              eng_finish,
   input  logic [OUT_W-1:0]  eng_dot,
   output logic              busy
);
   localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);

   localparam logic [ID_W:0]    NREQ_X   = (ID_W+1)'(NREQ);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    gnt_id_q;
   logic [CNT_W-1:0]   run_cnt_q;
   logic [VEC_W-1:0]   eng_a_q, eng_b_q;
   logic [OUT_W-1:0]   rsp_data_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic               rsp_err_q;

   logic               found;
   logic [ID_W-1:0]    winner;
   logic [ID_W:0]      cand;
   logic [VEC_W-1:0]   win_a, win_b;
   logic               timeout_hit;
   logic [ID_W-1:0]    next_ptr;

   // Cyclic search for the first valid request at or after rr_ptr.
   // NOTE: every combinational output gets a default before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (cand >= NREQ_X) cand = cand - NREQ_X;
         if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   // Winner operand mux and one-hot grant; grant only in IDLE, never in reset.
   always_comb begin
      win_a         = '0;
      win_b         = '0;
      bus.req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (winner == ID_W'(k)) begin
            win_a = bus.req_a[k*VEC_W +: VEC_W];
            win_b = bus.req_b[k*VEC_W +: VEC_W];
            bus.req_ready[k] = !rst && (state_q == IDLE) && found;
         end
      end
   end

   assign timeout_hit = (run_cnt_q == LAST_CNT);
   assign next_ptr    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      eng_clr = 1'b1;
      case (state_q)
         IDLE: if (found) state_d = LOAD;
         LOAD: state_d = RUN;
         RUN: begin
            eng_clr = 1'b0;
            // Finish takes priority over a timeout on the same cycle.
            if (eng_finish || timeout_hit) state_d = RESP;
         end
         RESP: begin
            eng_clr = 1'b0;               // engine keeps presenting its result
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) eng_clr = 1'b1;
   end

   // NOTE: the wide operand registers are reset too: their zero value is
   // visible on eng_a/eng_b and downstream logic may rely on it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         gnt_id_q   <= '0;
         run_cnt_q  <= '0;
         eng_a_q    <= '0;
         eng_b_q    <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  eng_a_q  <= win_a;
                  eng_b_q  <= win_b;
                  gnt_id_q <= winner;
               end
            end
            LOAD: run_cnt_q <= '0;
            RUN: begin
               run_cnt_q <= run_cnt_q + 1'b1;
               if (eng_finish) begin
                  rsp_data_q <= eng_dot;
                  rsp_err_q  <= 1'b0;
                  rsp_id_q   <= gnt_id_q;
               end else if (timeout_hit) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  rsp_id_q   <= gnt_id_q;
               end
            end
            RESP: begin
               if (bus.rsp_ready) rr_ptr_q <= next_ptr;
            end
            default: ;
         endcase
      end
   end

   assign eng_a        = eng_a_q;
   assign eng_b        = eng_b_q;
   assign busy         = (state_q != IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_vec_dot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vec_dot_arbiter
//   Scoreboard bench for vec_dot_arbiter. The main process owns all stimulus
//   (per-requester operation queues, rsp_ready policy, engine latency); a
//   negedge monitor predicts each grant from the round-robin rule, pushes
//   the expected response, and pops/compares whenever a response is taken.
//   A small engine model computes the Q4.11 dot product of eng_a/eng_b and
//   raises eng_finish a configurable number of cycles after clear drops.
// ---------------------------------------------------------------------------
module tb_vec_dot_arbiter;
   localparam int NREQ    = 4;
   localparam int VEC_W   = 256;
   localparam int OUT_W   = 16;
   localparam int TIMEOUT = 64;
   localparam int ID_W    = 2;
   localparam int ENG_LAT = 17;   // finish first seen on the 18th RUN cycle

   typedef struct packed {
      logic [VEC_W-1:0] a;
      logic [VEC_W-1:0] b;
   } op_t;

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        err;
      int          lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             eng_clr;
   logic [VEC_W-1:0] eng_a, eng_b;
   logic             eng_finish;
   logic [OUT_W-1:0] eng_dot;
   logic             busy;

   always #5 clk = ~clk;

   vec_dot_arbiter_if #(.NREQ(NREQ), .VEC_W(VEC_W), .OUT_W(OUT_W)) bus ();

   vec_dot_arbiter #(.NREQ(NREQ), .VEC_W(VEC_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .eng_clr    (eng_clr),
      .eng_a      (eng_a),
      .eng_b      (eng_b),
      .eng_finish (eng_finish),
      .eng_dot    (eng_dot),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dot_q411(logic [VEC_W-1:0] a, logic [VEC_W-1:0] b);
      longint acc = 0;
      for (int i = 0; i < 16; i++)
         acc += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      return 16'(acc >>> 11);
   endfunction

   function automatic int model_winner(logic [NREQ-1:0] v, int p);
      for (int i = 0; i < NREQ; i++)
         if (v[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      for (int i = 0; i < 16; i++) begin
         o.a[i*16 +: 16] = 16'($urandom);
         o.b[i*16 +: 16] = 16'($urandom);
      end
      return o;
   endfunction

   function automatic op_t lane_op(logic [15:0] av, logic [15:0] bv);
      op_t o;
      for (int i = 0; i < 16; i++) begin
         o.a[i*16 +: 16] = av;
         o.b[i*16 +: 16] = bv;
      end
      return o;
   endfunction

   // ---------------- engine model ----------------
   int eng_lat = ENG_LAT;   // < 0: never finishes
   int e_cnt   = 0;

   always @(posedge clk) begin
      if (eng_clr) e_cnt <= 0;
      else         e_cnt <= e_cnt + 1;
   end

   assign eng_finish = !eng_clr && (eng_lat >= 0) && (e_cnt >= eng_lat);
   assign eng_dot    = eng_finish ? dot_q411(eng_a, eng_b) : 16'hDEAD;

   // ---------------- stimulus state (main process) ----------------
   op_t req_q [NREQ][$];
   int  ready_mode = 1;      // 0: hold low, 1: always high, 2: random

   // ---------------- monitor state ----------------
   logic [NREQ-1:0] gnt_seen = '0;
   exp_t            exp_q[$];
   int              grant_log[$];
   int              model_ptr = 0;
   int              cyc = 0;
   int              last_gnt_cyc = 0;
   logic            prev_valid = 1'b0, prev_hold = 1'b0;
   logic [ID_W-1:0] prev_id = '0;
   logic [15:0]     prev_data = '0;
   logic            prev_err = 1'b0;
   logic [15:0]     last_rsp_data = '0;
   int              last_rsp_id = -1;
   logic            last_rsp_err = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         model_ptr = 0;
         gnt_seen  = '0;
         prev_valid = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         gnt_seen = bus.req_ready;
         if (bus.req_ready != '0) begin
            automatic int          w = model_winner(bus.req_valid, model_ptr);
            automatic logic [63:0] m = (w < 0) ? 64'd0 : (64'd1 << w);
            automatic exp_t        e;
            check("grant_onehot", 64'($onehot(bus.req_ready)), 64'd1);
            check("grant_winner", 64'(bus.req_ready), m);
            check("grant_while_busy", 64'(busy), 64'd0);
            if (w >= 0 && req_q[w].size() > 0) begin
               e.id  = w;
               e.err = (eng_lat < 0) || (eng_lat > TIMEOUT - 1);
               e.data = e.err ? 16'h0 : dot_q411(req_q[w][0].a, req_q[w][0].b);
               // grant cycle + LOAD + RUN cycles, then RESP
               e.lat = 2 + (e.err ? TIMEOUT : eng_lat + 1);
               exp_q.push_back(e);
               grant_log.push_back(w);
               last_gnt_cyc = cyc;
               model_ptr = (w + 1) % NREQ;
            end
         end
         if (prev_hold)
            check("rsp_hold", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data}),
                  64'({1'b1, prev_err, prev_id, prev_data}));
         if (bus.rsp_valid && !prev_valid) begin
            check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
               check("rsp_latency", 64'(cyc - last_gnt_cyc), 64'(exp_q[0].lat));
         end
         if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
            check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            check("rsp_err",  64'(bus.rsp_err),  64'(e.err));
            last_rsp_data = bus.rsp_data;
            last_rsp_id   = int'(bus.rsp_id);
            last_rsp_err  = bus.rsp_err;
         end
         prev_valid = bus.rsp_valid;
         prev_hold  = bus.rsp_valid && !bus.rsp_ready;
         prev_id    = bus.rsp_id;
         prev_data  = bus.rsp_data;
         prev_err   = bus.rsp_err;
      end
   end

   // ---------------- main process helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_seen[k] && req_q[k].size() > 0) void'(req_q[k].pop_front());
         bus.req_valid[k] = (req_q[k].size() > 0);
         bus.req_a[k*VEC_W +: VEC_W] = (req_q[k].size() > 0) ? req_q[k][0].a : '0;
         bus.req_b[k*VEC_W +: VEC_W] = (req_q[k].size() > 0) ? req_q[k][0].b : '0;
      end
      case (ready_mode)
         0:       bus.rsp_ready = 1'b0;
         1:       bus.rsp_ready = 1'b1;
         default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   function automatic bit pending();
      for (int k = 0; k < NREQ; k++)
         if (req_q[k].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_drain(string name, int budget);
      int n = 0;
      while ((busy || exp_q.size() > 0 || pending()) && n < budget) begin
         tick();
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   int  base;
   op_t op;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
      check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
      check("rst_eng_clr",   64'(eng_clr),       64'd1);
      check("rst_eng_a",     64'(|eng_a),        64'd0);
      check("rst_eng_b",     64'(|eng_b),        64'd0);
      check("rst_busy",      64'(busy),          64'd0);
      rst = 1'b0;
      tick();

      // Fairness: all four continuously valid, first results 1.0..4.0
      base = grant_log.size();
      for (int k = 0; k < NREQ; k++) begin
         op = '0;
         op.a[15:0] = 16'((k + 1) * 16'h0800);
         op.b[15:0] = 16'h0800;
         req_q[k].push_back(op);
         req_q[k].push_back(rand_op());
      end
      wait_drain("drain_fair", 2000);
      check("fair_count", 64'(grant_log.size() - base), 64'd8);
      for (int i = 0; i < 8; i++)
         if (base + i < grant_log.size())
            check("fair_order", 64'(grant_log[base + i]), 64'(i % NREQ));

      // Single request: 16 x (1.0 * 0.5) = 8.0
      base = grant_log.size();
      req_q[2].push_back(lane_op(16'h0800, 16'h0400));
      wait_drain("drain_single", 200);
      check("single_grants", 64'(grant_log.size() - base), 64'd1);
      check("single_data",   64'(last_rsp_data), 64'h4000);
      check("single_id",     64'(last_rsp_id),   64'd2);
      check("single_err",    64'(last_rsp_err),  64'd0);

      // Backpressure: response held 10 cycles, a new request must wait
      ready_mode = 0;
      req_q[0].push_back(rand_op());
      begin
         int n = 0;
         tick();
         while (!bus.rsp_valid && n < 200) begin tick(); n++; end
         check("bp_wait_rsp", 64'(bus.rsp_valid), 64'd1);
      end
      req_q[1].push_back(rand_op());
      repeat (10) tick();
      check("bp_still_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_no_grant",    64'(bus.req_ready), 64'd0);
      ready_mode = 1;
      tick();
      ready_mode = 0;
      tick();
      check("bp_released_busy",  64'(busy),          64'd0);
      check("bp_released_valid", 64'(bus.rsp_valid), 64'd0);
      check("bp_next_grant",     64'(bus.req_ready), 64'b0010);
      ready_mode = 1;
      wait_drain("drain_bp", 200);

      // Timeout: engine never finishes, then a normal request
      eng_lat = -1;
      req_q[3].push_back(rand_op());
      wait_drain("drain_timeout", 400);
      check("timeout_err",  64'(last_rsp_err),  64'd1);
      check("timeout_data", 64'(last_rsp_data), 64'd0);
      eng_lat = ENG_LAT;
      req_q[3].push_back(lane_op(16'h0800, 16'h0800));
      wait_drain("drain_after_timeout", 200);
      check("after_timeout_err",  64'(last_rsp_err),  64'd0);
      check("after_timeout_data", 64'(last_rsp_data), 64'h8000);

      // Finish on the last RUN cycle wins; one cycle later is a timeout
      eng_lat = TIMEOUT - 1;
      req_q[1].push_back(rand_op());
      wait_drain("drain_edge_finish", 400);
      check("edge_finish_err", 64'(last_rsp_err), 64'd0);
      eng_lat = TIMEOUT;
      req_q[2].push_back(rand_op());
      wait_drain("drain_edge_late", 400);
      check("edge_late_err", 64'(last_rsp_err), 64'd1);
      eng_lat = ENG_LAT;

      // Reset while RUN: pointer sits at 3, in-flight op for 0 is dropped
      req_q[2].push_back(rand_op());
      wait_drain("drain_pre_rst", 200);
      req_q[0].push_back(rand_op());
      repeat (6) tick();
      check("pre_rst_busy", 64'(busy), 64'd1);
      req_q[1].push_back(rand_op());
      req_q[3].push_back(rand_op());
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy",      64'(busy),          64'd0);
      check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("mid_rst_eng_clr",   64'(eng_clr),       64'd1);
      base = grant_log.size();
      wait_drain("drain_post_rst", 400);
      check("post_rst_grants", 64'(grant_log.size() - base), 64'd2);
      if (grant_log.size() >= base + 2) begin
         check("post_rst_first",  64'(grant_log[base]),     64'd1);
         check("post_rst_second", 64'(grant_log[base + 1]), 64'd3);
      end

      // Randomised batches
      ready_mode = 2;
      for (int t = 0; t < 12; t++) begin
         case ($urandom_range(0, 3))
            0:       eng_lat = $urandom_range(0, TIMEOUT + 4);
            default: eng_lat = ENG_LAT;
         endcase
         for (int k = 0; k < NREQ; k++) begin
            int n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) req_q[k].push_back(rand_op());
         end
         wait_drain("drain_rand", 3000);
      end
      ready_mode = 1;
      eng_lat = ENG_LAT;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
